// File: rtl/llama_layer_dot_acc.sv
// llama_layer_dot_acc: accumulates a vector of unsigned products, then rounds, shifts and saturates the sum to OUT_WIDTH
//   ap_clk, ap_rst_n       : clock, async active-low reset
//   start, len, idle       : transaction launch (sampled in IDLE), vector length, idle status
//   in_valid/ready/data    : product stream, accepted only in ACC
//   out_valid/ready/data   : requantized result handshake, out_sat flags clipping
module llama_layer_dot_acc #(
  parameter int PROD_WIDTH = 44,
  parameter int ACC_WIDTH  = 56,
  parameter int OUT_WIDTH  = 22,
  parameter int LEN_WIDTH  = 10,
  parameter int FRAC_SHIFT = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PROD_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_sat,
  output logic                  idle
);
  typedef enum logic [1:0] {IDLE, ACC, ROUND, OUT} state_t;
  localparam logic [ACC_WIDTH:0] HALF = (ACC_WIDTH+1)'(1) << (FRAC_SHIFT - 1);
  state_t state, state_n;
  logic [ACC_WIDTH-1:0] acc;
  logic [LEN_WIDTH-1:0] cnt, len_q;
  logic [ACC_WIDTH:0] rounded, r;
  logic sat, last_beat;
  // one extra bit keeps the rounding add from wrapping at the top of the range
  assign rounded   = {1'b0, acc} + HALF;
  assign r         = rounded >> FRAC_SHIFT;
  assign sat       = |(r >> OUT_WIDTH);
  assign last_beat = in_valid && cnt == len_q - LEN_WIDTH'(1);
  assign in_ready  = state == ACC;
  assign out_valid = state == OUT;
  assign idle      = state == IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = start ? (len == '0 ? ROUND : ACC) : IDLE;
      ACC:   state_n = last_beat ? ROUND : ACC;
      ROUND: state_n = OUT;
      OUT:   state_n = out_ready ? IDLE : OUT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      len_q    <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        acc   <= '0;
        cnt   <= '0;
        len_q <= len;
      end
      if (state == ACC && in_valid) begin
        acc <= acc + ACC_WIDTH'(in_data);
        cnt <= cnt + LEN_WIDTH'(1);
      end
      if (state == ROUND) begin
        out_data <= sat ? '1 : r[OUT_WIDTH-1:0];
        out_sat  <= sat;
      end
    end
  end
endmodule

// File: doc/llama_layer_dot_acc.md
# llama_layer_dot_acc

Dot-product accumulator and requantizer that sits directly downstream of the layer's unsigned 22x22→44-bit product multiplier. It consumes a stream of 44-bit unsigned products for one vector of programmable length, sums them in a wide accumulator, then rounds, shifts and saturates the sum back to the 22-bit operand format. The single requantized result is offered to the next layer stage over a valid/ready handshake.

## Interface
- PROD_WIDTH, 44: width of the incoming unsigned product.
- ACC_WIDTH, 56: accumulator width; must be ≥ PROD_WIDTH + LEN_WIDTH.
- OUT_WIDTH, 22: width of the requantized unsigned result.
- LEN_WIDTH, 10: width of the vector-length input.
- FRAC_SHIFT, 16: right shift applied to the sum; legal range 1..ACC_WIDTH-1.

- ap_clk, in, 1: single clock; all logic is rising-edge.
- ap_rst_n, in, 1: asynchronous, active-low reset.
- start, in, 1: begin a transaction; sampled only in IDLE.
- len, in, LEN_WIDTH: number of products to accumulate; latched on the accepted start.
- in_valid, in, 1: product beat valid.
- in_ready, out, 1: block accepts a product; high only in ACC.
- in_data, in, PROD_WIDTH: unsigned product.
- out_valid, out, 1: result valid.
- out_ready, in, 1: consumer accepts the result.
- out_data, out, OUT_WIDTH: requantized result.
- out_sat, out, 1: result was clipped; qualified by out_valid.
- idle, out, 1: high in IDLE.

## Operation
- States are IDLE, ACC, ROUND and OUT.
- **IDLE**
  - start=1 with len≠0: latch len, clear acc and beat counter, go to ACC.
  - start=1 with len=0: clear acc, go to ROUND.
  - start=0: stay in IDLE.
- **ACC**
  - in_ready=1.
  - Each beat with in_valid&&in_ready: acc ← acc + zero-extended in_data, and the counter increments.
  - The beat on which the counter reaches len−1 is the final beat; go to ROUND on the next edge.
  - Cycles with in_valid=0 do not change state.
- **ROUND**, exactly one cycle:
  - Form r = (acc + 2^(FRAC_SHIFT−1)) >> FRAC_SHIFT, computed in ACC_WIDTH+1 bits so it cannot wrap. This is round-half-up.
  - If r > 2^OUT_WIDTH−1: out_data ← all ones and out_sat ← 1.
  - Otherwise: out_data ← r[OUT_WIDTH−1:0] and out_sat ← 0.
  - Go to OUT.
- **OUT**
  - out_valid=1. out_data and out_sat hold stable until out_ready=1.
  - On out_valid&&out_ready, go to IDLE.
- start is ignored outside IDLE. in_data is ignored whenever in_ready=0.
- The accumulator cannot overflow for legal parameters: (2^LEN_WIDTH−1)·(2^PROD_WIDTH−1) < 2^ACC_WIDTH.
- Reset values:
  - State = IDLE; idle=1.
  - in_ready=0 and out_valid=0.
  - out_data=0 and out_sat=0.
  - acc, counter and latched len = 0.
- Reset asserted mid-transaction aborts it immediately, with no output produced. The next start after reset behaves normally.

## Timing
- in_ready, out_valid and idle are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.
- start accepted at edge t → in_ready=1 during cycle t+1.
- Final beat accepted at edge t → ROUND in cycle t+1 → out_valid=1 from cycle t+2.
- len=0: start at edge t → out_valid=1 from cycle t+2, with out_data=0 and out_sat=0.
- Accepted result at edge t → idle=1 in cycle t+1, and a new start is accepted at edge t+1.
- Throughput with no stalls: len+3 cycles per vector.

## Test plan
1. Basic sum: len=4, four beats of 0x10000 back-to-back, out_ready=1 → out_data=4, out_sat=0, out_valid exactly 2 cycles after the 4th beat.
2. Rounding: len=1 with 0x18000 → out_data=2; len=1 with 0x17FFF → out_data=1; len=1 with 0x7FFF → out_data=0.
3. Saturation: len=2, beats 2^43 and 2^43 (sum 2^44, shifted 2^28) → out_data=0x3FFFFF, out_sat=1. The next vector, len=1 with 0x10000, → out_sat=0, out_data=1.
4. Backpressure:
   - Setup: len=3, with in_valid gaps of 2 cycles between beats, and out_ready held low for 5 cycles after out_valid.
   - Accumulation: result is correct and gaps are not counted.
   - Output hold: out_data is stable while stalled.
   - start: pulses of start during ACC and OUT are ignored.
5. Zero length: start with len=0 → out_valid 2 cycles later with out_data=0; in_ready stays 0 throughout.
6. Reset mid-operation: ap_rst_n low after 2 of 5 beats → all outputs return to reset values asynchronously. A fresh len=2 transaction of 0x20000, 0x20000 → out_data=4.
